lamp_monitor: RTL and testbench
===============================

LAMP_MONITOR -- requirements
Module: lamp_monitor

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port clr, input, 1 bit: asynchronous, active-low reset (low = reset).
REQ-003 SHALL have port tick, input, 1 bit: one-clk-wide 1 Hz seconds strobe.
REQ-004 SHALL have ports r1,g1,y1,r2,g2,y2, inputs, 1 bit each: observed lamp drives for direction 1 (main road) and direction 2 (side road), synchronous to clk.
REQ-005 SHALL have port hold, input, 1 bit: controller pause active; freezes all timers.
REQ-006 SHALL have port override, input, 1 bit: controller in clear/stop mode; suppresses the sequence and yellow checks.
REQ-007 SHALL have port fault_ack, input, 1 bit: one-clk pulse that clears a sticky fault.
REQ-008 SHALL have port fault, output, 1 bit: sticky fault flag.
REQ-009 SHALL have port fault_code, output, 3 bits: 0 none, 1 conflict, 2 bad encoding, 3 bad sequence, 4 yellow timing.
REQ-010 SHALL have port mon_state, output, 2 bits: 0 IDLE, 1 RUN, 2 FAULT.
REQ-011 SHALL have port dur1, output, 8 bits: seconds elapsed in direction 1's current lamp, binary.
REQ-012 SHALL have port cycle_cnt, output, 8 bits: completed direction-1 cycles, binary.

Function
REQ-013 SHALL register all lamp inputs once (stage S1) and hold the previous S1 value (S2); all checks SHALL use S1 against S2.
REQ-014 SHALL assert fault on the second rising clk edge after a violating lamp pattern first appears at the inputs.
REQ-015 State machine: IDLE->RUN when any lamp in S1 is lit; RUN->IDLE when all six lamps are dark; RUN->FAULT on any violation; FAULT->IDLE on fault_ack (or on an ack and a violation in the same cycle, see REQ-021).
REQ-016 Conflict (code 1): in RUN, (g1|y1)&(g2|y2) true in S1.
REQ-017 Encoding (code 2): in RUN, either direction has other than exactly one lamp lit.
REQ-018 Sequence (code 3): with override low, a per-direction change other than G->Y, Y->R or R->G.
REQ-019 Yellow timing (code 4): with override low, the direction's yellow counter is cleared on yellow entry and incremented on each tick while yellow and hold is low; fault if Y->R occurs with count != 5, or immediately when the count reaches 6.
REQ-020 Priority when several faults coincide: 1 > 2 > 3 > 4; only the first fault's code is latched until acknowledged.
REQ-021 fault_ack coinciding with a new violation: the new violation SHALL win and be latched.
REQ-022 dur1 SHALL clear on any direction-1 lamp change, increment on tick when hold is low, and saturate at 255.
REQ-023 cycle_cnt SHALL increment on each direction-1 R->G change, including while override is high, and wrap from 255 to 0.
REQ-024 While override is high, the yellow counters SHALL be held at 0 and lamp history SHALL keep updating; conflict and encoding checks SHALL stay active.
REQ-025 A tick during hold SHALL change no counter.

Reset
REQ-026 While clr is low: fault=0, fault_code=0, mon_state=IDLE, dur1=0, cycle_cnt=0, S1/S2=all dark, yellow counters=0.
REQ-027 Reset asserted mid-operation SHALL take effect immediately and discard any latched fault.

Structure
REQ-028 Shared package lamp_mon_pkg SHALL hold the fault-code constants, the state encoding and YELLOW_TICKS=5.
REQ-029 Per-direction logic (encoding, sequence, yellow timer) SHALL be one sub-module, lamp_dir_checker, instantiated twice.

Verification
REQ-030 Normal cycle (G1 for 35 ticks, Y1 for 5, then R1 for 30 with G2 for 25 and Y2 for 5), repeated 3 times -> fault=0, cycle_cnt=3.
REQ-031 g1=1 and g2=1 together -> fault=1, fault_code=1 two clks later; persists until fault_ack.
REQ-032 Direction 1 G->R directly with override=0 -> code 3; the same change with override=1 -> no fault.
REQ-033 Y1 held for 4 ticks then R1 -> code 4; Y1 held for 6 ticks -> code 4 on the 6th tick; Y1 held 10 ticks with hold=1 after tick 2, then 3 more ticks -> no fault.
REQ-034 r1=1 and y1=1 together while g2=1 -> code 1, not 2 (priority); fault_ack in the same cycle as a new violation -> fault stays 1.
REQ-035 clr pulled low during FAULT with dur1=17 -> all outputs 0 and IDLE immediately; all lamps dark -> stays IDLE.

Source files
------------

// File: rtl/lamp_mon_pkg.sv
// Shared types and constants for the traffic-lamp monitor: state and fault
// encodings, the per-direction lamp triple, and the yellow dwell length.
package lamp_mon_pkg;

    typedef enum logic [1:0] {
        MON_IDLE  = 2'd0,
        MON_RUN   = 2'd1,
        MON_FAULT = 2'd2
    } mon_state_e;

    typedef enum logic [2:0] {
        FC_NONE     = 3'd0,
        FC_CONFLICT = 3'd1,
        FC_ENCODING = 3'd2,
        FC_SEQUENCE = 3'd3,
        FC_YELLOW   = 3'd4
    } fault_code_e;

    typedef struct packed {
        logic r;
        logic y;
        logic g;
    } lamp_t;

    localparam int                YCNT_W       = 3;
    localparam logic [YCNT_W-1:0] YELLOW_TICKS = 3'd5;

    // A direction is well formed only when exactly one of its lamps is lit.
    function automatic logic lamp_valid(input lamp_t l);
        return (l.r ^ l.y ^ l.g) & ~(l.r & l.y & l.g);
    endfunction

endpackage

// File: rtl/lamp_dir_checker.sv
// Per-direction checks: lamp encoding, legal G->Y->R->G progression, and the
// yellow dwell timer measured in seconds ticks.
module lamp_dir_checker
    import lamp_mon_pkg::*;
(
    input  logic  clk,
    input  logic  clr,
    input  lamp_t s1,
    input  lamp_t s2,
    input  logic  tick,
    input  logic  hold,
    input  logic  override,
    output logic  enc_err,
    output logic  seq_err,
    output logic  yel_err
);

    logic [YCNT_W-1:0] ycnt_q, ycnt_d;
    logic valid_now, valid_prev, both_valid, changed;
    logic g_to_y, y_to_r, r_to_g;
    logic in_yellow, yel_entry, yel_tick;

    always_comb begin
        valid_now  = lamp_valid(s1);
        valid_prev = lamp_valid(s2);
        both_valid = valid_now & valid_prev;
        changed    = (s1 != s2);

        g_to_y = both_valid & s2.g & s1.y;
        y_to_r = both_valid & s2.y & s1.r;
        r_to_g = both_valid & s2.r & s1.g;

        in_yellow = valid_now & s1.y;
        yel_entry = in_yellow & ~(valid_prev & s2.y);
        yel_tick  = in_yellow & ~yel_entry & tick & ~hold;

        enc_err = ~valid_now;
        seq_err = ~override & both_valid & changed & ~(g_to_y | y_to_r | r_to_g);
        // Short yellow is caught at Y->R; long yellow is caught on the tick
        // that would take the count past the allowed dwell.
        yel_err = ~override & ((y_to_r & (ycnt_q != YELLOW_TICKS)) |
                               (yel_tick & (ycnt_q == YELLOW_TICKS)));

        ycnt_d = ycnt_q;
        if (override || yel_entry) begin
            ycnt_d = '0;
        end else if (yel_tick && (ycnt_q != '1)) begin
            ycnt_d = ycnt_q + YCNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            ycnt_q <= '0;
        end else begin
            ycnt_q <= ycnt_d;
        end
    end

endmodule

// File: rtl/lamp_monitor.sv
// Traffic-lamp monitor: registers the observed lamp drives twice, checks the
// two-stage history for violations and latches a sticky, prioritised fault.
module lamp_monitor
    import lamp_mon_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       tick,
    input  logic       r1,
    input  logic       g1,
    input  logic       y1,
    input  logic       r2,
    input  logic       g2,
    input  logic       y2,
    input  logic       hold,
    input  logic       override,
    input  logic       fault_ack,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [1:0] mon_state,
    output logic [7:0] dur1,
    output logic [7:0] cycle_cnt
);

    lamp_t s1_dir1_q, s1_dir1_d, s1_dir2_q, s1_dir2_d;
    lamp_t s2_dir1_q, s2_dir1_d, s2_dir2_q, s2_dir2_d;

    mon_state_e  state_q, state_d;
    fault_code_e code_q, code_d, viol_code;

    logic [7:0] dur1_q, dur1_d;
    logic [7:0] cycle_cnt_q, cycle_cnt_d;

    logic enc_err1, seq_err1, yel_err1;
    logic enc_err2, seq_err2, yel_err2;
    logic any_lit, conflict, evaluate;
    logic dir1_changed, dir1_r_to_g;

    lamp_dir_checker u_dir1 (
        .clk      (clk),
        .clr      (clr),
        .s1       (s1_dir1_q),
        .s2       (s2_dir1_q),
        .tick     (tick),
        .hold     (hold),
        .override (override),
        .enc_err  (enc_err1),
        .seq_err  (seq_err1),
        .yel_err  (yel_err1)
    );

    lamp_dir_checker u_dir2 (
        .clk      (clk),
        .clr      (clr),
        .s1       (s1_dir2_q),
        .s2       (s2_dir2_q),
        .tick     (tick),
        .hold     (hold),
        .override (override),
        .enc_err  (enc_err2),
        .seq_err  (seq_err2),
        .yel_err  (yel_err2)
    );

    always_comb begin
        s1_dir1_d = '{r: r1, y: y1, g: g1};
        s1_dir2_d = '{r: r2, y: y2, g: g2};
        s2_dir1_d = s1_dir1_q;
        s2_dir2_d = s1_dir2_q;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            s1_dir1_q <= '0;
            s1_dir2_q <= '0;
            s2_dir1_q <= '0;
            s2_dir2_q <= '0;
        end else begin
            s1_dir1_q <= s1_dir1_d;
            s1_dir2_q <= s1_dir2_d;
            s2_dir1_q <= s2_dir1_d;
            s2_dir2_q <= s2_dir2_d;
        end
    end

    // Violations are also judged on the IDLE->RUN cycle so a bad first pattern
    // is latched on the same edge as any later one.
    always_comb begin
        any_lit  = |{s1_dir1_q, s1_dir2_q};
        conflict = (s1_dir1_q.g | s1_dir1_q.y) & (s1_dir2_q.g | s1_dir2_q.y);
        evaluate = (state_q != MON_FAULT) | fault_ack;

        viol_code = FC_NONE;
        if (any_lit) begin
            if (conflict) begin
                viol_code = FC_CONFLICT;
            end else if (enc_err1 || enc_err2) begin
                viol_code = FC_ENCODING;
            end else if (seq_err1 || seq_err2) begin
                viol_code = FC_SEQUENCE;
            end else if (yel_err1 || yel_err2) begin
                viol_code = FC_YELLOW;
            end
        end

        state_d = state_q;
        code_d  = code_q;
        case (state_q)
            MON_IDLE: begin
                if (any_lit) begin
                    state_d = MON_RUN;
                end
            end
            MON_RUN: begin
                if (!any_lit) begin
                    state_d = MON_IDLE;
                end
            end
            MON_FAULT: begin
                if (fault_ack) begin
                    state_d = MON_IDLE;
                    code_d  = FC_NONE;
                end
            end
            default: begin
                state_d = MON_IDLE;
                code_d  = FC_NONE;
            end
        endcase

        // An acknowledge that coincides with a fresh violation re-latches it.
        if (evaluate && (viol_code != FC_NONE)) begin
            state_d = MON_FAULT;
            code_d  = viol_code;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= MON_IDLE;
            code_q  <= FC_NONE;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        dir1_changed = (s1_dir1_q != s2_dir1_q);
        dir1_r_to_g  = lamp_valid(s1_dir1_q) & lamp_valid(s2_dir1_q) &
                       s2_dir1_q.r & s1_dir1_q.g;

        dur1_d = dur1_q;
        if (dir1_changed) begin
            dur1_d = '0;
        end else if (tick && !hold && (dur1_q != 8'hFF)) begin
            dur1_d = dur1_q + 8'd1;
        end

        cycle_cnt_d = cycle_cnt_q;
        if (dir1_r_to_g) begin
            cycle_cnt_d = cycle_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            dur1_q      <= '0;
            cycle_cnt_q <= '0;
        end else begin
            dur1_q      <= dur1_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    always_comb begin
        fault      = (state_q == MON_FAULT);
        fault_code = code_q;
        mon_state  = state_q;
        dur1       = dur1_q;
        cycle_cnt  = cycle_cnt_q;
    end

endmodule

// File: tb/tb_lamp_monitor.sv
// Directed bench for lamp_monitor: a table of lamp steps with hand-computed
// expectations, plus hand-written multi-cycle corner sequences.
module tb_lamp_monitor;

    logic       clk       = 1'b0;
    logic       clr       = 1'b0;
    logic       tick      = 1'b0;
    logic       r1        = 1'b0;
    logic       g1        = 1'b0;
    logic       y1        = 1'b0;
    logic       r2        = 1'b0;
    logic       g2        = 1'b0;
    logic       y2        = 1'b0;
    logic       hold      = 1'b0;
    logic       override  = 1'b0;
    logic       fault_ack = 1'b0;
    logic       fault;
    logic [2:0] fault_code;
    logic [1:0] mon_state;
    logic [7:0] dur1;
    logic [7:0] cycle_cnt;

    int checks = 0;
    int errors = 0;

    // Lamp patterns as {r1, y1, g1, r2, y2, g2}.
    localparam logic [5:0] DARK  = 6'b000000;
    localparam logic [5:0] R1R2  = 6'b100100;
    localparam logic [5:0] G1R2  = 6'b001100;
    localparam logic [5:0] Y1R2  = 6'b010100;
    localparam logic [5:0] R1G2  = 6'b100001;
    localparam logic [5:0] R1Y2  = 6'b100010;
    localparam logic [5:0] G1G2  = 6'b001001;
    localparam logic [5:0] RY1R2 = 6'b110100;
    localparam logic [5:0] RY1G2 = 6'b110001;

    typedef struct {
        logic [5:0] lamps;
        logic       ovr;
        logic       ack;
        int         nticks;
        logic       exp_fault;
        logic [2:0] exp_code;
        logic [1:0] exp_state;
        logic [7:0] exp_dur1;
        logic [7:0] exp_cyc;
    } vec_t;

    vec_t vecs[15];

    lamp_monitor dut (
        .clk        (clk),
        .clr        (clr),
        .tick       (tick),
        .r1         (r1),
        .g1         (g1),
        .y1         (y1),
        .r2         (r2),
        .g2         (g2),
        .y2         (y2),
        .hold       (hold),
        .override   (override),
        .fault_ack  (fault_ack),
        .fault      (fault),
        .fault_code (fault_code),
        .mon_state  (mon_state),
        .dur1       (dur1),
        .cycle_cnt  (cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_status(input string tag, input logic ef, input logic [2:0] ec,
                                input logic [1:0] es, input logic [7:0] ed, input logic [7:0] ecc);
        checkOutput({tag, "_fault"}, 32'(fault), 32'(ef));
        checkOutput({tag, "_code"}, 32'(fault_code), 32'(ec));
        checkOutput({tag, "_state"}, 32'(mon_state), 32'(es));
        checkOutput({tag, "_dur1"}, 32'(dur1), 32'(ed));
        checkOutput({tag, "_cycle"}, 32'(cycle_cnt), 32'(ecc));
    endtask

    task automatic set_lamps_now(input logic [5:0] lamps);
        {r1, y1, g1, r2, y2, g2} = lamps;
    endtask

    task automatic applyStimulus(input logic [5:0] lamps, input logic ovr);
        @(negedge clk);
        set_lamps_now(lamps);
        override = ovr;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        fault_ack = 1'b1;
        @(negedge clk);
        fault_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        set_lamps_now(DARK);
        override  = 1'b0;
        hold      = 1'b0;
        tick      = 1'b0;
        fault_ack = 1'b0;
        clr       = 1'b0;
        #1;
        check_status(tag, 1'b0, 3'd0, 2'd0, 8'd0, 8'd0);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        vecs[0]  = '{R1R2,  1'b0, 1'b0, 3, 1'b0, 3'd0, 2'd1, 8'd3, 8'd0};
        vecs[1]  = '{G1R2,  1'b0, 1'b0, 2, 1'b0, 3'd0, 2'd1, 8'd2, 8'd1};
        vecs[2]  = '{Y1R2,  1'b0, 1'b0, 5, 1'b0, 3'd0, 2'd1, 8'd5, 8'd1};
        vecs[3]  = '{R1G2,  1'b0, 1'b0, 4, 1'b0, 3'd0, 2'd1, 8'd4, 8'd1};
        vecs[4]  = '{R1Y2,  1'b0, 1'b0, 5, 1'b0, 3'd0, 2'd1, 8'd9, 8'd1};
        vecs[5]  = '{G1R2,  1'b0, 1'b0, 0, 1'b0, 3'd0, 2'd1, 8'd0, 8'd2};
        vecs[6]  = '{R1R2,  1'b0, 1'b0, 1, 1'b1, 3'd3, 2'd2, 8'd1, 8'd2};
        vecs[7]  = '{R1R2,  1'b0, 1'b1, 0, 1'b0, 3'd0, 2'd1, 8'd1, 8'd2};
        vecs[8]  = '{G1R2,  1'b1, 1'b0, 0, 1'b0, 3'd0, 2'd1, 8'd0, 8'd3};
        vecs[9]  = '{R1R2,  1'b1, 1'b0, 0, 1'b0, 3'd0, 2'd1, 8'd0, 8'd3};
        vecs[10] = '{G1G2,  1'b1, 1'b0, 0, 1'b1, 3'd1, 2'd2, 8'd0, 8'd4};
        vecs[11] = '{G1G2,  1'b0, 1'b1, 0, 1'b1, 3'd1, 2'd2, 8'd0, 8'd4};
        vecs[12] = '{RY1R2, 1'b0, 1'b1, 0, 1'b1, 3'd2, 2'd2, 8'd0, 8'd4};
        vecs[13] = '{R1R2,  1'b0, 1'b1, 0, 1'b0, 3'd0, 2'd1, 8'd0, 8'd4};
        vecs[14] = '{DARK,  1'b0, 1'b0, 0, 1'b0, 3'd0, 2'd0, 8'd0, 8'd4};

        $display("[TB] start");
        repeat (2) @(negedge clk);
        do_reset("reset0");

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].lamps, vecs[i].ovr);
            if (vecs[i].ack) pulse_ack();
            do_ticks(vecs[i].nticks);
            check_status($sformatf("row%0d", i), vecs[i].exp_fault, vecs[i].exp_code,
                         vecs[i].exp_state, vecs[i].exp_dur1, vecs[i].exp_cyc);
        end

        // Conflict latency: fault appears on the second edge, then stays sticky.
        do_reset("reset_conflict");
        @(negedge clk);
        set_lamps_now(G1G2);
        @(negedge clk);
        checkOutput("conflict_edge1_fault", 32'(fault), 32'd0);
        @(negedge clk);
        checkOutput("conflict_edge2_fault", 32'(fault), 32'd1);
        checkOutput("conflict_edge2_code", 32'(fault_code), 32'd1);
        applyStimulus(DARK, 1'b0);
        repeat (4) @(negedge clk);
        checkOutput("conflict_sticky_fault", 32'(fault), 32'd1);
        pulse_ack();
        checkOutput("conflict_ack_fault", 32'(fault), 32'd0);
        checkOutput("conflict_ack_code", 32'(fault_code), 32'd0);
        checkOutput("conflict_ack_state", 32'(mon_state), 32'd0);

        // Short yellow: 4 ticks then red.
        do_reset("reset_yshort");
        applyStimulus(G1R2, 1'b0);
        applyStimulus(Y1R2, 1'b0);
        do_ticks(4);
        applyStimulus(R1R2, 1'b0);
        checkOutput("yshort_fault", 32'(fault), 32'd1);
        checkOutput("yshort_code", 32'(fault_code), 32'd4);

        // Long yellow: the 6th tick itself raises the fault.
        do_reset("reset_ylong");
        applyStimulus(G1R2, 1'b0);
        applyStimulus(Y1R2, 1'b0);
        do_ticks(5);
        checkOutput("ylong_5_fault", 32'(fault), 32'd0);
        do_ticks(1);
        checkOutput("ylong_6_fault", 32'(fault), 32'd1);
        checkOutput("ylong_6_code", 32'(fault_code), 32'd4);

        // Hold freezes both the yellow timer and dur1.
        do_reset("reset_yhold");
        applyStimulus(G1R2, 1'b0);
        applyStimulus(Y1R2, 1'b0);
        do_ticks(2);
        hold = 1'b1;
        do_ticks(8);
        hold = 1'b0;
        do_ticks(3);
        checkOutput("yhold_dur1", 32'(dur1), 32'd5);
        applyStimulus(R1R2, 1'b0);
        checkOutput("yhold_fault", 32'(fault), 32'd0);
        checkOutput("yhold_state", 32'(mon_state), 32'd1);

        // Conflict outranks encoding.
        do_reset("reset_prio");
        applyStimulus(RY1G2, 1'b0);
        checkOutput("prio_fault", 32'(fault), 32'd1);
        checkOutput("prio_code", 32'(fault_code), 32'd1);

        // Three full cycles with legal timing.
        do_reset("reset_normal");
        applyStimulus(R1R2, 1'b0);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(G1R2, 1'b0);
            do_ticks(35);
            checkOutput($sformatf("normal%0d_dur1", c), 32'(dur1), 32'd35);
            applyStimulus(Y1R2, 1'b0);
            do_ticks(5);
            applyStimulus(R1G2, 1'b0);
            do_ticks(25);
            applyStimulus(R1Y2, 1'b0);
            do_ticks(5);
        end
        checkOutput("normal_fault", 32'(fault), 32'd0);
        checkOutput("normal_cycle", 32'(cycle_cnt), 32'd3);
        checkOutput("normal_state", 32'(mon_state), 32'd1);

        // dur1 saturates at 255.
        do_reset("reset_sat");
        applyStimulus(G1R2, 1'b0);
        do_ticks(254);
        checkOutput("sat_254", 32'(dur1), 32'd254);
        do_ticks(3);
        checkOutput("sat_255", 32'(dur1), 32'd255);

        // cycle_cnt wraps, counting R->G under override.
        do_reset("reset_wrap");
        @(negedge clk);
        override = 1'b1;
        set_lamps_now(R1R2);
        for (int i = 0; i < 255; i++) begin
            @(negedge clk);
            set_lamps_now(G1R2);
            @(negedge clk);
            set_lamps_now(R1R2);
        end
        repeat (3) @(negedge clk);
        checkOutput("wrap_255", 32'(cycle_cnt), 32'd255);
        checkOutput("wrap_fault", 32'(fault), 32'd0);
        set_lamps_now(G1R2);
        repeat (3) @(negedge clk);
        checkOutput("wrap_0", 32'(cycle_cnt), 32'd0);

        // Reset in the middle of a fault clears everything at once.
        do_reset("reset_mid");
        applyStimulus(R1R2, 1'b0);
        applyStimulus(G1R2, 1'b0);
        do_ticks(17);
        applyStimulus(G1G2, 1'b0);
        checkOutput("mid_pre_fault", 32'(fault), 32'd1);
        checkOutput("mid_pre_dur1", 32'(dur1), 32'd17);
        checkOutput("mid_pre_cycle", 32'(cycle_cnt), 32'd1);
        @(negedge clk);
        clr = 1'b0;
        #1;
        check_status("mid_clr", 1'b0, 3'd0, 2'd0, 8'd0, 8'd0);
        set_lamps_now(DARK);
        override = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("mid_idle_state", 32'(mon_state), 32'd0);
        checkOutput("mid_idle_fault", 32'(fault), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
